// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode
// classes, ALU operation codes and the bundle of datapath control signals.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Opcodes are kept 8 bits wide so any OPCODE_W in 4..8 compares zero-extended.
    localparam logic [7:0] OP_RTYPE  = 8'd0;
    localparam logic [7:0] OP_LOAD   = 8'd1;
    localparam logic [7:0] OP_STORE  = 8'd2;
    localparam logic [7:0] OP_BRANCH = 8'd3;
    localparam logic [7:0] OP_ADDI   = 8'd4;
    localparam logic [7:0] OP_JUMP   = 8'd11;
    localparam logic [7:0] OP_HALT   = 8'd15;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_RFUNC = 2'd2;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       regdst;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] aluop;
    } ctrl_t;

    // True for opcodes that proceed from DECODE into EXEC.
    function automatic logic op_runs(input logic [7:0] op);
        return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_ADDI) || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: maps current state, latched opcode and the
// Zero/Memready inputs onto the datapath control bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  state_e              i_state,
    input  logic [OPCODE_W-1:0] i_op,
    input  logic                i_zero,
    input  logic                i_memready,
    output ctrl_t               o_ctrl
);

    logic [7:0] w_op;
    assign w_op = 8'(i_op);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.memread = 1'b1;
                // Instruction register and PC+4 update only in the completing cycle.
                if (i_memready) begin
                    o_ctrl.irwrite = 1'b1;
                    o_ctrl.pcwrite = 1'b1;
                    o_ctrl.alusrc  = 1'b1;
                    o_ctrl.aluop   = ALU_ADD;
                end
            end
            ST_EXEC: begin
                case (w_op)
                    OP_RTYPE: begin
                        o_ctrl.regdst = 1'b1;
                        o_ctrl.aluop  = ALU_RFUNC;
                    end
                    OP_LOAD, OP_STORE, OP_ADDI: begin
                        o_ctrl.alusrc = 1'b1;
                        o_ctrl.aluop  = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        o_ctrl.branch  = 1'b1;
                        o_ctrl.aluop   = ALU_SUB;
                        o_ctrl.pcwrite = i_zero;
                    end
                    OP_JUMP: begin
                        o_ctrl.jump    = 1'b1;
                        o_ctrl.pcwrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (w_op == OP_LOAD)  o_ctrl.memread  = 1'b1;
                if (w_op == OP_STORE) o_ctrl.memwrite = 1'b1;
            end
            ST_WB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = (w_op == OP_LOAD);
                o_ctrl.regdst   = (w_op == OP_RTYPE);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with HALT,
// illegal-opcode detection and a wrapping retired-instruction counter.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                Memready,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                Branch,
    output logic                Jump,
    output logic                Regdst,
    output logic                ALUsrc,
    output logic                Regwrite,
    output logic                Memread,
    output logic                Memtoreg,
    output logic                Memwrite,
    output logic                IRwrite,
    output logic                PCwrite,
    output logic [2:0]          State,
    output logic                Illegal,
    output logic                Halted,
    output logic [CNT_W-1:0]    Retired
);

    state_e              r_state;
    logic [OPCODE_W-1:0] r_op;
    logic [CNT_W-1:0]    r_retired;
    logic [7:0]          w_opcode;
    logic [7:0]          w_op_ext;
    ctrl_t               w_ctrl;
    ctrl_t               w_ctrl_gated;

    assign w_opcode = 8'(Opcode);
    assign w_op_ext = 8'(r_op);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_FETCH;
            r_op      <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (Memready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_op <= Opcode;
                    if (op_runs(w_opcode))       r_state <= ST_EXEC;
                    else if (w_opcode == OP_HALT) r_state <= ST_HALT;
                    else                          r_state <= ST_FETCH;
                end
                ST_EXEC: begin
                    case (w_op_ext)
                        OP_RTYPE, OP_ADDI: r_state <= ST_WB;
                        OP_LOAD, OP_STORE: r_state <= ST_MEM;
                        OP_BRANCH, OP_JUMP: begin
                            r_state   <= ST_FETCH;
                            r_retired <= r_retired + CNT_W'(1);
                        end
                        default: r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // Stores finish here; loads still need a register write.
                    if (Memready) begin
                        if (w_op_ext == OP_LOAD) begin
                            r_state <= ST_WB;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    end
                end
                ST_WB: begin
                    r_state   <= ST_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    ctrl_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_decode (
        .i_state   (r_state),
        .i_op      (r_op),
        .i_zero    (Zero),
        .i_memready(Memready),
        .o_ctrl    (w_ctrl)
    );

    // Reset forces the state to FETCH, whose decode would otherwise drive Memread.
    assign w_ctrl_gated = Rst ? '0 : w_ctrl;

    assign ALUop    = ALUOP_W'(w_ctrl_gated.aluop);
    assign Branch   = w_ctrl_gated.branch;
    assign Jump     = w_ctrl_gated.jump;
    assign Regdst   = w_ctrl_gated.regdst;
    assign ALUsrc   = w_ctrl_gated.alusrc;
    assign Regwrite = w_ctrl_gated.regwrite;
    assign Memread  = w_ctrl_gated.memread;
    assign Memtoreg = w_ctrl_gated.memtoreg;
    assign Memwrite = w_ctrl_gated.memwrite;
    assign IRwrite  = w_ctrl_gated.irwrite;
    assign PCwrite  = w_ctrl_gated.pcwrite;

    assign State   = r_state;
    assign Retired = r_retired;
    assign Halted  = (r_state == ST_HALT);
    assign Illegal = !Rst && (r_state == ST_DECODE) &&
                     !op_runs(w_opcode) && (w_opcode != OP_HALT);

endmodule
